// File: rtl/button_pkg.sv
// Shared definitions for the button event classifier: FSM state encoding,
// default tick thresholds and a small state-decoding helper.
package button_pkg;

    // Classifier FSM states; the 2-bit encoding is shared with the stopwatch top.
    typedef enum logic [1:0] {
        ST_WAIT_REL = 2'd0,
        ST_IDLE     = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_LONG     = 2'd3
    } btn_state_e;

    // Default hold time before a long press, in ~1 kHz ticks.
    localparam int LONG_MS_DEF   = 1000;
    // Default auto-repeat period after a long press, in ~1 kHz ticks (0 = off).
    localparam int REPEAT_MS_DEF = 200;
    // Default timer width; holds max(LONG_MS, REPEAT_MS) - 1.
    localparam int CNT_W_DEF     = 11;

    // True for the states in which the button counts as pressed.
    function automatic logic is_held_state(btn_state_e s);
        return (s == ST_PRESSED) || (s == ST_LONG);
    endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Signal bundle between the debounced-button source and the press classifier.
// The master side supplies the tick and button level; the slave side (the
// classifier) returns the event pulses and the held level.
interface button_press_classifier_if;

    logic clk_en;        // ~1 kHz single-cycle tick
    logic button_in;     // debounced level, active-low
    logic short_press;   // one-cycle pulse on release before the long threshold
    logic long_press;    // one-cycle pulse when the hold reaches the long threshold
    logic repeat_pulse;  // one-cycle pulse every repeat period while held long
    logic held;          // level, high while the button counts as pressed

    modport master (
        output clk_en,
        output button_in,
        input  short_press,
        input  long_press,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  clk_en,
        input  button_in,
        output short_press,
        output long_press,
        output repeat_pulse,
        output held
    );

endinterface

// File: rtl/button_press_classifier.sv
// Turns the debounced active-low button level into single-cycle short-press,
// long-press and auto-repeat pulses plus a held level. Press and release are
// detected on every clk edge; only hold-time measurement uses clk_en.
module button_press_classifier
    import button_pkg::*;
#(
    parameter int LONG_MS   = LONG_MS_DEF,
    parameter int REPEAT_MS = REPEAT_MS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    button_press_classifier_if.slave bus
);

    // Reject thresholds that are out of range or do not fit the timer.
    generate
        if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
            $error("button_press_classifier: CNT_W must be in 1..30");
        end
        if (LONG_MS < 2 || LONG_MS > 2047) begin : g_bad_long
            $error("button_press_classifier: LONG_MS must be in 2..2047");
        end
        if (REPEAT_MS < 0 || REPEAT_MS > 2047) begin : g_bad_repeat
            $error("button_press_classifier: REPEAT_MS must be in 0..2047");
        end
        if ((LONG_MS - 1) >= (1 << CNT_W)) begin : g_long_too_wide
            $error("button_press_classifier: LONG_MS - 1 does not fit in CNT_W bits");
        end
        if (REPEAT_MS > 0 && (REPEAT_MS - 1) >= (1 << CNT_W)) begin : g_repeat_too_wide
            $error("button_press_classifier: REPEAT_MS - 1 does not fit in CNT_W bits");
        end
    endgenerate

    // Terminal timer values; the timer never goes past these.
    localparam bit               REPEAT_EN   = (REPEAT_MS != 0);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_EN ? (REPEAT_MS - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    btn_state_e       r_state;
    btn_state_e       w_state_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_next;
    logic             r_short;
    logic             r_long;
    logic             r_repeat;
    logic             r_held;
    logic             w_short_next;
    logic             w_long_next;
    logic             w_repeat_next;
    logic             w_held_next;
    logic             w_btn_low;

    assign w_btn_low = ~bus.button_in;

    // State, timer and registered outputs; reset parks the FSM until a release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_WAIT_REL;
            r_timer  <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_timer  <= w_timer_next;
            r_short  <= w_short_next;
            r_long   <= w_long_next;
            r_repeat <= w_repeat_next;
            r_held   <= w_held_next;
        end
    end

    // Next-state, timer and pulse decode; a release always beats a threshold tick.
    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_short_next  = 1'b0;
        w_long_next   = 1'b0;
        w_repeat_next = 1'b0;

        case (r_state)
            ST_WAIT_REL: begin
                // A button stuck low out of reset must be released first.
                if (!w_btn_low) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (w_btn_low) begin
                    w_state_next = ST_PRESSED;
                    w_timer_next = '0;
                end
            end

            ST_PRESSED: begin
                if (!w_btn_low) begin
                    w_short_next = 1'b1;
                    w_state_next = ST_IDLE;
                    w_timer_next = '0;
                end else if (bus.clk_en) begin
                    if (r_timer == LONG_LAST) begin
                        w_long_next  = 1'b1;
                        w_state_next = ST_LONG;
                        w_timer_next = '0;
                    end else begin
                        w_timer_next = r_timer + CNT_ONE;
                    end
                end
            end

            ST_LONG: begin
                if (!w_btn_low) begin
                    w_state_next = ST_IDLE;
                    w_timer_next = '0;
                end else if (bus.clk_en && REPEAT_EN) begin
                    // With repeat disabled the timer simply stays parked at 0.
                    if (r_timer == REPEAT_LAST) begin
                        w_repeat_next = 1'b1;
                        w_timer_next  = '0;
                    end else begin
                        w_timer_next = r_timer + CNT_ONE;
                    end
                end
            end

            default: begin
                w_state_next = ST_WAIT_REL;
                w_timer_next = '0;
            end
        endcase

        w_held_next = is_held_state(w_state_next);
    end

    assign bus.short_press  = r_short;
    assign bus.long_press   = r_long;
    assign bus.repeat_pulse = r_repeat;
    assign bus.held         = r_held;

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: two instances (repeat every 4 ticks and
// repeat disabled) share one stimulus stream; a tick-counting reference model
// predicts every output on every clock.
module tb_button_press_classifier;

    localparam int LONG_T = 10;
    localparam int REP_A  = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   en_cnt   = 0;

    // Reference model: armed after a release, pressed level, ticks counted in this press.
    bit         m_armed   [2];
    bit         m_pressed [2];
    int         m_ticks   [2];
    logic [3:0] exp_v [2];   // {short, long, repeat, held}
    logic [3:0] obs_v [2];
    logic [3:0] mid_v [2];   // sampled between negedge drive and posedge
    int         n_short [2];
    int         n_long  [2];
    int         n_rep   [2];
    int         long_at [$];
    int         rep_at  [$];

    button_press_classifier_if bus_a ();
    button_press_classifier_if bus_b ();

    button_press_classifier #(.LONG_MS(LONG_T), .REPEAT_MS(REP_A), .CNT_W(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    button_press_classifier #(.LONG_MS(LONG_T), .REPEAT_MS(0), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    // One clock of the specification's behaviour, counted in ticks since the press.
    function automatic void model_step(input int d, input logic rst_v, input logic btn, input logic en);
        int   rep;
        logic s, l, r;
        rep = (d == 0) ? REP_A : 0;
        s = 1'b0; l = 1'b0; r = 1'b0;
        if (rst_v) begin
            m_armed[d] = 1'b0; m_pressed[d] = 1'b0; m_ticks[d] = 0;
        end else if (!m_armed[d]) begin
            if (btn) m_armed[d] = 1'b1;
        end else if (!m_pressed[d]) begin
            if (!btn) begin m_pressed[d] = 1'b1; m_ticks[d] = 0; end
        end else if (btn) begin
            s = (m_ticks[d] < LONG_T);
            m_pressed[d] = 1'b0;
        end else if (en) begin
            m_ticks[d] = m_ticks[d] + 1;
            l = (m_ticks[d] == LONG_T);
            r = (rep != 0) && (m_ticks[d] > LONG_T) && (((m_ticks[d] - LONG_T) % rep) == 0);
        end
        exp_v[d] = {s, l, r, m_pressed[d]};
    endfunction

    // Drive one clock of stimulus at negedge, advance, sample 1 time unit after posedge.
    task automatic cycle(input logic rst_v, input logic btn);
        logic en;
        @(negedge clk);
        en     = (en_cnt == 4);
        en_cnt = (en_cnt + 1) % 5;
        rst = rst_v;
        bus_a.button_in = btn; bus_b.button_in = btn;
        bus_a.clk_en    = en;  bus_b.clk_en    = en;
        #1;
        mid_v[0] = {bus_a.short_press, bus_a.long_press, bus_a.repeat_pulse, bus_a.held};
        mid_v[1] = {bus_b.short_press, bus_b.long_press, bus_b.repeat_pulse, bus_b.held};
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) model_step(d, rst_v, btn, en);
        obs_v[0] = {bus_a.short_press, bus_a.long_press, bus_a.repeat_pulse, bus_a.held};
        obs_v[1] = {bus_b.short_press, bus_b.long_press, bus_b.repeat_pulse, bus_b.held};
        for (int d = 0; d < 2; d++) begin
            n_short[d] += int'(obs_v[d][3]);
            n_long[d]  += int'(obs_v[d][2]);
            n_rep[d]   += int'(obs_v[d][1]);
        end
        if (obs_v[0][2] === 1'b1) long_at.push_back(m_ticks[0]);
        if (obs_v[0][1] === 1'b1) rep_at.push_back(m_ticks[0]);
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin n_short[d] = 0; n_long[d] = 0; n_rep[d] = 0; end
        long_at.delete();
        rep_at.delete();
    endtask

    task automatic test_reset();
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== 8'h00)
                $display("FAIL reset_state t=%0t got a=%b b=%b want a=0000 b=0000", $time, obs_v[0], obs_v[1]);
            else n_pass++;
        end
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b0);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_stuck t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (n_short[0] + n_long[0] + n_rep[0] + int'(obs_v[0][0]) !== 0)
            $display("FAIL stuck_low_events got %0d want 0", n_short[0] + n_long[0] + n_rep[0] + int'(obs_v[0][0]));
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, (i < 3) ? 1'b1 : 1'b0);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_arm t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (obs_v[0] !== 4'b0001)
            $display("FAIL press_latency got %b want 0001", obs_v[0]);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_arm_rel t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
    endtask

    task automatic test_short_press();
        bit reached;
        clear_counts();
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            cycle(1'b0, 1'b0);
            reached = (m_ticks[0] == 6);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_short t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (!reached) $display("FAIL short_hold_timeout got ticks=%0d want 6", m_ticks[0]);
        else n_pass++;
        cycle(1'b0, 1'b1);
        n_checks++;
        if ({obs_v[0], obs_v[1]} !== 8'b1000_1000)
            $display("FAIL short_after_release got a=%b b=%b want a=1000 b=1000", obs_v[0], obs_v[1]);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_short_idle t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (n_short[0] !== 1 || n_long[0] !== 0 || n_short[1] !== 1)
            $display("FAIL short_counts got short=%0d long=%0d shortb=%0d want 1 0 1", n_short[0], n_long[0], n_short[1]);
        else n_pass++;
    endtask

    task automatic test_long_repeat();
        bit reached;
        clear_counts();
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            cycle(1'b0, 1'b0);
            reached = (m_ticks[0] == 22);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_long t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (!reached) $display("FAIL long_hold_timeout got ticks=%0d want 22", m_ticks[0]);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_long_rel t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (long_at.size() != 1 || long_at[0] != LONG_T || n_short[0] != 0)
            $display("FAIL long_timing got n=%0d short=%0d want one long at tick %0d, no short", long_at.size(), n_short[0], LONG_T);
        else n_pass++;
        n_checks++;
        if (rep_at.size() != 3 || rep_at[0] != 14 || rep_at[1] != 18 || rep_at[2] != 22)
            $display("FAIL repeat_ticks got n=%0d want ticks 14 18 22", rep_at.size());
        else n_pass++;
        n_checks++;
        if (n_rep[1] !== 0 || n_long[1] !== 1)
            $display("FAIL norepeat_counts got rep=%0d long=%0d want 0 1", n_rep[1], n_long[1]);
        else n_pass++;
    endtask

    task automatic test_release_on_tick();
        bit reached;
        clear_counts();
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            cycle(1'b0, 1'b0);
            reached = (m_ticks[0] == LONG_T - 1) && (en_cnt == 4);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_tickrel t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (!reached) $display("FAIL tickrel_timeout got ticks=%0d want %0d", m_ticks[0], LONG_T - 1);
        else n_pass++;
        cycle(1'b0, 1'b1);
        n_checks++;
        if ({obs_v[0], obs_v[1]} !== 8'b1000_1000)
            $display("FAIL release_wins got a=%b b=%b want a=1000 b=1000", obs_v[0], obs_v[1]);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_tickrel_idle t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (n_long[0] !== 0 || n_short[0] !== 1)
            $display("FAIL tickrel_counts got long=%0d short=%0d want 0 1", n_long[0], n_short[0]);
        else n_pass++;
    endtask

    task automatic test_repeat_disabled();
        bit reached;
        clear_counts();
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            cycle(1'b0, 1'b0);
            reached = (m_ticks[1] == 40);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_norep t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (!reached) $display("FAIL norep_timeout got ticks=%0d want 40", m_ticks[1]);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_norep_rel t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (n_long[1] !== 1 || n_rep[1] !== 0)
            $display("FAIL norep_counts got long=%0d rep=%0d want 1 0", n_long[1], n_rep[1]);
        else n_pass++;
        n_checks++;
        if (n_rep[0] !== (40 - LONG_T) / REP_A)
            $display("FAIL rep40_count got %0d want %0d", n_rep[0], (40 - LONG_T) / REP_A);
        else n_pass++;
    endtask

    task automatic test_reset_mid_long();
        bit reached;
        clear_counts();
        reached = 1'b0;
        for (int i = 0; i < 300 && !reached; i++) begin
            cycle(1'b0, 1'b0);
            reached = (m_ticks[0] == 13);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_prerst t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (!reached || obs_v[0] !== 4'b0001)
            $display("FAIL prerst_held got a=%b ticks=%0d want 0001 at 13", obs_v[0], m_ticks[0]);
        else n_pass++;
        cycle(1'b1, 1'b0);
        n_checks++;
        if ({mid_v[0], mid_v[1]} !== 8'h00)
            $display("FAIL async_reset got a=%b b=%b want a=0000 b=0000", mid_v[0], mid_v[1]);
        else n_pass++;
        cycle(1'b1, 1'b0);
        clear_counts();
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b0);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_postrst t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (n_short[0] + n_long[0] + n_rep[0] + int'(obs_v[0][0]) !== 0)
            $display("FAIL postrst_events got %0d want 0", n_short[0] + n_long[0] + n_rep[0] + int'(obs_v[0][0]));
        else n_pass++;
        for (int i = 0; i < 80; i++) begin
            // release for 3 clocks, then press again and hold past the long threshold
            cycle(1'b0, (i < 3) ? 1'b1 : 1'b0);
            n_checks++;
            if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                $display("FAIL cyc_repress t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
            else n_pass++;
        end
        n_checks++;
        if (n_long[0] !== 1 || n_short[0] !== 0)
            $display("FAIL repress_counts got long=%0d short=%0d want 1 0", n_long[0], n_short[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        int gap, hold;
        for (int it = 0; it < 25; it++) begin
            gap  = int'($urandom_range(1, 15));
            hold = int'($urandom_range(1, 120));
            for (int i = 0; i < gap + hold; i++) begin
                cycle(1'b0, (i < gap) ? 1'b1 : 1'b0);
                n_checks++;
                if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
                    $display("FAIL cyc_random it=%0d t=%0t got a=%b b=%b want a=%b b=%b", it, $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
                else n_pass++;
            end
        end
        cycle(1'b0, 1'b1);
        n_checks++;
        if ({obs_v[0], obs_v[1]} !== {exp_v[0], exp_v[1]})
            $display("FAIL random_final t=%0t got a=%b b=%b want a=%b b=%b", $time, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        bus_a.button_in = 1'b0; bus_b.button_in = 1'b0;
        bus_a.clk_en    = 1'b0; bus_b.clk_en    = 1'b0;
        test_reset();
        $display("test_reset done: %0d/%0d", n_pass, n_checks);
        test_short_press();
        $display("test_short_press done: %0d/%0d", n_pass, n_checks);
        test_long_repeat();
        $display("test_long_repeat done: %0d/%0d", n_pass, n_checks);
        test_release_on_tick();
        $display("test_release_on_tick done: %0d/%0d", n_pass, n_checks);
        test_repeat_disabled();
        $display("test_repeat_disabled done: %0d/%0d", n_pass, n_checks);
        test_reset_mid_long();
        $display("test_reset_mid_long done: %0d/%0d", n_pass, n_checks);
        test_random();
        $display("test_random done: %0d/%0d", n_pass, n_checks);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_press_classifier.md
# button_press_classifier

Classifies the debounced, active-low button level into single-cycle event pulses: short press, long press and auto-repeat while held. Sits directly downstream of the button debouncer and shares its ~1 kHz clock enable. Its pulses drive the stopwatch control FSM (start/stop, lap, reset-on-long-press) in the 50 MHz domain.

## Interface
- LONG_MS, 1000: hold time, in clk_en ticks, before `long_press` fires; legal range 2..2047.
- REPEAT_MS, 200: period, in clk_en ticks, of `repeat_pulse` after `long_press`; 0 disables repeat; legal range 0..2047.
- CNT_W, 11: timer width; must hold max(LONG_MS, REPEAT_MS) − 1.
- clk  input  1  50 MHz system clock.
- rst  input  1  asynchronous, active-high reset.
- clk_en  input  1  one-cycle ~1 kHz tick, same source as the debouncer.
- button_in  input  1  debounced button level, active-low, already synchronous to clk.
- short_press  output  1  one-clk pulse on release when hold < LONG_MS ticks.
- long_press  output  1  one-clk pulse when hold reaches LONG_MS ticks.
- repeat_pulse  output  1  one-clk pulse every REPEAT_MS ticks after long_press while still held.
- held  output  1  level; high while the FSM considers the button pressed.

## Operation
- All outputs are registered; reset value 0 for every output; state WAIT_REL; timer 0.
- FSM states:
  - WAIT_REL: button_in high → IDLE. It blocks a press that is stuck low out of reset.
  - IDLE: button_in low → PRESSED; timer cleared; held set.
  - PRESSED: release → short_press, IDLE. On clk_en with timer == LONG_MS−1 → long_press, LONG; timer cleared. Otherwise on clk_en, timer + 1.
  - LONG: release → IDLE with no pulse. On clk_en with REPEAT_MS ≠ 0 and timer == REPEAT_MS−1 → repeat_pulse; timer cleared. Otherwise on clk_en, timer + 1.
- held is 1 in PRESSED and LONG, and 0 otherwise.
- Release and the threshold tick in the same cycle: release wins. PRESSED yields short_press only; LONG yields no repeat_pulse.
- The timer advances only on clk_en, never wraps and never exceeds its threshold − 1.
- Press/release detection uses the raw clk edge, not clk_en.
- rst asserted mid-operation: outputs drop to 0 asynchronously and the FSM returns to WAIT_REL. A pulse in flight is lost.
- At most one of short_press, long_press and repeat_pulse is high in any cycle.

## Timing
- Press latency: button_in sampled low at edge k → held = 1 after edge k.
- Short press: release sampled at edge m → short_press high for exactly the cycle after edge m; held = 0 from the same edge.
- Long press: long_press is high after the edge that samples the LONG_MS-th clk_en counted in PRESSED.
  - The clk_en coincident with the press edge is not counted.
- Repeat: the first repeat_pulse follows the REPEAT_MS-th clk_en after long_press. Subsequent pulses are every REPEAT_MS ticks.
- Minimum recognised press: 1 clk cycle, which the upstream debounce guarantees is ≥ 20 ms.

## Structure
- Shared package `button_pkg`: FSM state encodings (WAIT_REL=0, IDLE=1, PRESSED=2, LONG=3, 2-bit) and the default tick constants LONG_MS/REPEAT_MS. The stopwatch top uses these for consistent timing.
- Single module, no sub-module. The timer and FSM are small enough to stay in one file.
- A parameter check is required: elaboration error if LONG_MS < 2 or a threshold does not fit CNT_W.

## Test plan
Bench overrides LONG_MS=10 and REPEAT_MS=4, with clk_en every 5 clk.
- Reset with button_in=0 held 30 clk, then release, then press → no pulse and held=0 until release. After release, the press sets held one cycle later.
- Press for 6 clk_en ticks, then release → exactly one short_press, the cycle after the release edge; no long_press.
- Press held 22 ticks → long_press after tick 10, then repeat_pulse after ticks 14, 18 and 22. Release gives no further pulse.
- Release on the same edge as the 10th tick → short_press only; long_press never asserts.
- REPEAT_MS=0 instance, held 40 ticks → single long_press and zero repeat_pulse.
- Assert rst for 2 clk while in LONG mid-hold → all outputs 0 immediately and state WAIT_REL. The held button gives no events until it is released and re-pressed.
